// File: rtl/cla_arbiter.sv
// Two requesters share one carry-lookahead adder through a round-robin grant.
// Sums land in a single-entry output register with valid/ready backpressure.

module carry_lookahead_adder #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   sum_o
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;
  logic             acc;
  logic             prod;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // Each carry is built directly from generate/propagate terms, not from the previous carry.
  always_comb begin
    carry    = '0;
    acc      = 1'b0;
    prod     = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc  = acc | (prod & gen[j]);
        prod = prod & prop[j];
      end
      carry[i+1] = acc;
    end
  end

  assign sum_o = {carry[WIDTH], prop ^ carry[WIDTH-1:0]};

endmodule

module cla_arbiter #(
  parameter int WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  output logic             o_req0_ready,
  input  logic             i_req1_valid,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  output logic             o_req1_ready,
  output logic             o_res_valid,
  output logic [WIDTH:0]   o_res_data,
  output logic             o_res_id,
  input  logic             i_res_ready
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   data_q, data_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;

  logic             can_accept;
  logic             grant0, grant1;
  logic             accept;
  logic [WIDTH-1:0] add_a, add_b;
  logic [WIDTH:0]   add_sum;

  assign o_res_valid = (state_q == ST_FULL);
  assign o_res_data  = data_q;
  assign o_res_id    = id_q;

  assign can_accept = !o_res_valid || i_res_ready;

  // On a conflict the requester that did not win last time gets the slot.
  assign grant0 = i_req0_valid && (!i_req1_valid || last_grant_q);
  assign grant1 = i_req1_valid && (!i_req0_valid || !last_grant_q);

  assign o_req0_ready = grant0 && can_accept && !i_rst;
  assign o_req1_ready = grant1 && can_accept && !i_rst;

  assign accept = (i_req0_valid && o_req0_ready) || (i_req1_valid && o_req1_ready);

  assign add_a = grant1 ? i_req1_a : i_req0_a;
  assign add_b = grant1 ? i_req1_b : i_req0_b;

  carry_lookahead_adder #(.WIDTH(WIDTH)) u_adder (
    .a_i   (add_a),
    .b_i   (add_b),
    .sum_o (add_sum)
  );

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      data_d       = add_sum;
      id_d         = grant1;
      last_grant_d = grant1;
    end
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (!accept && i_res_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_EMPTY;
      data_q       <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_cla_arbiter.sv
// Bench for cla_arbiter: directed scenarios, then random traffic, all against a behavioural model.
module tb_cla_arbiter;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         v0, v1, rdy0, rdy1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         res_valid, res_id, res_ready;
  logic [W:0]   res_data;

  always #5 clk = ~clk;

  cla_arbiter #(.WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req0_valid (v0),
    .i_req0_a     (a0),
    .i_req0_b     (b0),
    .o_req0_ready (rdy0),
    .i_req1_valid (v1),
    .i_req1_a     (a1),
    .i_req1_b     (b1),
    .o_req1_ready (rdy1),
    .o_res_valid  (res_valid),
    .o_res_data   (res_data),
    .o_res_id     (res_id),
    .i_res_ready  (res_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: what the output stage should hold and who won last.
  int m_valid, m_data, m_id, m_last;
  bit acc0_f, acc1_f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cycle();
    int win;
    bit can;
    #1;
    win = -1;
    if (v0 && v1)  win = 1 - m_last;
    else if (v0)   win = 0;
    else if (v1)   win = 1;
    can = (m_valid == 0) || res_ready;
    if (rst || !can) win = -1;
    check("ready0",    32'(rdy0),      32'(win == 0));
    check("ready1",    32'(rdy1),      32'(win == 1));
    check("res_valid", 32'(res_valid), 32'(m_valid));
    check("res_data",  32'(res_data),  32'(m_data));
    check("res_id",    32'(res_id),    32'(m_id));
    acc0_f = (win == 0);
    acc1_f = (win == 1);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = 0; m_id = 0; m_last = 1;
    end else if (win >= 0) begin
      m_data  = (win == 0) ? int'(a0) + int'(b0) : int'(a1) + int'(b1);
      m_id    = win;
      m_valid = 1;
      m_last  = win;
    end else if (m_valid != 0 && res_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic set_req(input bit rv0, input int ra0, input int rb0,
                         input bit rv1, input int ra1, input int rb1);
    v0 = rv0; a0 = W'(ra0); b0 = W'(rb0);
    v1 = rv1; a1 = W'(ra1); b1 = W'(rb1);
  endtask

  task automatic expect_out(input string tag, input int data, input int id);
    #1;
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_data"},  32'(res_data),  32'(data));
    check({tag, "_id"},    32'(res_id),    32'(id));
  endtask

  initial begin
    rst = 1'b1; res_ready = 1'b1;
    set_req(1, 7, 7, 1, 2, 2);
    m_valid = 0; m_data = 0; m_id = 0; m_last = 1;
    @(posedge clk);
    @(negedge clk);

    // Reset held with both requesters asking: nothing accepted.
    cycle(); cycle();
    rst = 1'b0;

    // Single requester, 5+6.
    set_req(1, 5, 6, 0, 0, 0);
    cycle();
    expect_out("t2", 4'b1011, 0);
    set_req(0, 0, 0, 0, 0, 0);
    cycle();

    // Conflicts alternate, starting from req0 after reset.
    rst = 1'b1; cycle(); rst = 1'b0;
    set_req(1, 7, 7, 1, 2, 2);
    cycle(); expect_out("t3a", 4'b1110, 0);
    cycle(); expect_out("t3b", 4'b0100, 1);
    cycle(); expect_out("t3c", 4'b1110, 0);
    cycle(); expect_out("t3d", 4'b0100, 1);

    // Stall: result held, both readies low, pointer frozen.
    set_req(1, 3, 1, 0, 0, 0);
    cycle(); expect_out("t4", 4'b0100, 0);
    res_ready = 1'b0;
    set_req(1, 2, 2, 1, 6, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(); expect_out("t4_hold", 4'b0100, 0);
    end
    res_ready = 1'b1;
    cycle(); expect_out("t4_r1", 4'b0111, 1);
    set_req(1, 2, 2, 0, 0, 0);
    cycle(); expect_out("t4_r0", 4'b0100, 0);

    // Back-to-back results from req1.
    set_req(0, 0, 0, 1, 0, 1);
    cycle(); expect_out("t5a", 4'b0001, 1);
    set_req(0, 0, 0, 1, 7, 7);
    cycle(); expect_out("t5b", 4'b1110, 1);

    // Reset while a result is held; next conflict goes to req0.
    rst = 1'b1;
    set_req(1, 1, 1, 1, 1, 2);
    cycle();
    #1 check("t6_valid", 32'(res_valid), 32'd0);
    rst = 1'b0;
    cycle(); expect_out("t6", 4'b0010, 0);

    // Random traffic: producers hold a pair until it is accepted.
    set_req(0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 2000; n++) begin
      if (!v0 || acc0_f) begin
        v0 = ($urandom_range(0, 9) < 6); a0 = W'($urandom); b0 = W'($urandom);
      end
      if (!v1 || acc1_f) begin
        v1 = ($urandom_range(0, 9) < 6); a1 = W'($urandom); b1 = W'($urandom);
      end
      res_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
